fetch_unit: RTL

Front-end fetch unit that produces entries into the instruction queue. It keeps the fetch PC and issues one aligned fetch-block request at a time to the icache. Each returned block is held in a one-entry output buffer and pushed into the instruction queue when the queue has room. On branch mispredict it redirects, and it discards any stale in-flight response.

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: icache request/response, redirect input and instruction-queue push port.
interface fetch_if #(
  parameter int unsigned SS_WIDTH = 2
);
  logic                         redirect;
  logic [31:0]                  redirect_pc;
  logic                         imem_req;
  logic [31:0]                  imem_addr;
  logic                         imem_resp;
  logic [SS_WIDTH*32-1:0]       imem_rdata;
  logic                         iq_full;
  logic                         iq_push;
  logic [SS_WIDTH-1:0][31:0]    iq_inst;
  logic [SS_WIDTH-1:0]          iq_valid;
  logic [SS_WIDTH-1:0]          iq_pred;
  logic [31:0]                  iq_pc;

  modport master (
    input  redirect, redirect_pc, imem_resp, imem_rdata, iq_full,
    output imem_req, imem_addr, iq_push, iq_inst, iq_valid, iq_pred, iq_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_resp, imem_rdata, iq_full,
    input  imem_req, imem_addr, iq_push, iq_inst, iq_valid, iq_pred, iq_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: one outstanding icache block request, one-entry output buffer, redirect with stale-response discard.
// Optional static backward-taken prediction is enabled by defining FETCH_STATIC_PRED_EN.
module fetch_unit #(
  parameter int unsigned SS_WIDTH = 2,
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);
  localparam int unsigned BLK_BYTES  = SS_WIDTH * 4;
  localparam logic [31:0] ALIGN_MASK = ~32'(BLK_BYTES - 1);

  typedef enum logic [1:0] {REQ, DRAIN, DISCARD} state_t;

  state_t                    state, state_d;
  logic [31:0]               fetch_pc, fetch_pc_d;
  logic [31:0]               req_addr;
  logic [31:0]               blk_pc;
  logic [31:0]               offset;
  logic [SS_WIDTH-1:0]       cap_valid, cap_pred;
  logic [31:0]               cap_next_pc;
  logic                      load, consume, flush;
  logic                      req_c, push_c;
  logic [SS_WIDTH-1:0][31:0] buf_inst;
  logic [SS_WIDTH-1:0]       buf_valid, buf_pred;
  logic [31:0]               buf_pc;

  assign blk_pc = fetch_pc & ALIGN_MASK;
  assign offset = (fetch_pc - blk_pc) >> 2;

  // Lane valids, predictions and next fetch PC for the block being captured
`ifdef FETCH_STATIC_PRED_EN
  logic        found;
  logic [31:0] lane;
  always_comb begin
    cap_valid   = '0;
    cap_pred    = '0;
    cap_next_pc = blk_pc + 32'(BLK_BYTES);
    found       = 1'b0;
    lane        = '0;
    for (int unsigned i = 0; i < SS_WIDTH; i++) begin
      lane = bus.imem_rdata[32*i +: 32];
      if (32'(i) >= offset && !found) begin
        cap_valid[i] = 1'b1;
        if (lane[6:0] == 7'b1100011 && lane[31]) begin
          cap_pred[i] = 1'b1;
          found       = 1'b1;
          cap_next_pc = blk_pc + 32'(i * 4) +
                        {{19{lane[31]}}, lane[31], lane[7], lane[30:25], lane[11:8], 1'b0};
        end
      end
    end
  end
`else
  always_comb begin
    cap_valid   = '0;
    cap_pred    = '0;
    cap_next_pc = blk_pc + 32'(BLK_BYTES);
    for (int unsigned i = 0; i < SS_WIDTH; i++) begin
      cap_valid[i] = (32'(i) >= offset);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
    end else begin
      state <= state_d;
    end
  end

  // Next state, fetch PC and handshake strobes; redirect overrides everything
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    load       = 1'b0;
    consume    = 1'b0;
    flush      = 1'b0;
    req_c      = 1'b0;
    push_c     = 1'b0;
    case (state)
      REQ: begin
        req_c = 1'b1;
        if (bus.imem_resp) begin
          load       = 1'b1;
          fetch_pc_d = cap_next_pc;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        push_c = 1'b1;
        if (!bus.iq_full) begin
          consume = 1'b1;
          state_d = REQ;
        end
      end
      DISCARD: begin
        req_c = 1'b1;
        if (bus.imem_resp) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
    if (bus.redirect) begin
      push_c     = 1'b0;
      load       = 1'b0;
      consume    = 1'b0;
      flush      = 1'b1;
      fetch_pc_d = bus.redirect_pc;
      if (state == REQ && !bus.imem_resp) state_d = DISCARD;
      else if (state == DISCARD)           state_d = DISCARD;
      else                                 state_d = REQ;
    end
    if (rst) begin
      req_c  = 1'b0;
      push_c = 1'b0;
    end
  end

  // Request address only moves when (re)entering REQ, so DISCARD holds the old one
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      req_addr  <= RESET_PC & ALIGN_MASK;
      buf_inst  <= '0;
      buf_valid <= '0;
      buf_pred  <= '0;
      buf_pc    <= '0;
    end else begin
      fetch_pc <= fetch_pc_d;
      if (state_d == REQ) req_addr <= fetch_pc_d & ALIGN_MASK;
      if (flush || consume) begin
        buf_inst  <= '0;
        buf_valid <= '0;
        buf_pred  <= '0;
        buf_pc    <= '0;
      end else if (load) begin
        buf_inst  <= bus.imem_rdata;
        buf_valid <= cap_valid;
        buf_pred  <= cap_pred;
        buf_pc    <= blk_pc;
      end
    end
  end

  assign bus.imem_req  = req_c;
  assign bus.imem_addr = req_addr;
  assign bus.iq_push   = push_c;
  assign bus.iq_inst   = buf_inst;
  assign bus.iq_valid  = buf_valid;
  assign bus.iq_pred   = buf_pred;
  assign bus.iq_pc     = buf_pc;
endmodule
